// File: rtl/clkdiv_pkg.sv
// Shared constants and helpers for the programmable clock divider.
package clkdiv_pkg;

    // Reset half-period: 1 ms output period from a 100 MHz clock.
    localparam int unsigned DEFAULT_HALF_C = 50000;

    // Largest supported number of divider channels.
    localparam int unsigned MAX_CH = 16;

    // Width of a channel index; never narrower than one bit.
    function automatic int unsigned ch_idx_w(input int unsigned num_ch);
        return (num_ch <= 1) ? 1 : $clog2(num_ch);
    endfunction

endpackage

// File: rtl/prog_clock_divider_if.sv
// Divisor-write handshake: the writer drives valid/channel/half-period,
// the divider answers with ready.
interface prog_clock_divider_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 32
);
    import clkdiv_pkg::*;

    localparam int unsigned IDX_W = ch_idx_w(NUM_CH);

    logic             cfg_valid;
    logic [IDX_W-1:0] cfg_ch;
    logic [CNT_W-1:0] cfg_half;
    logic             cfg_ready;

    modport master (output cfg_valid, cfg_ch, cfg_half, input cfg_ready);
    modport slave  (input cfg_valid, cfg_ch, cfg_half, output cfg_ready);

endinterface

// File: rtl/clkdiv_channel.sv
// One divider channel: half-period counter, toggling output, rise strobe,
// and a single-entry pending slot so a new divisor lands on a toggle boundary.
module clkdiv_channel
    import clkdiv_pkg::*;
#(
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned DEFAULT_HALF = DEFAULT_HALF_C
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable_i,
    input  logic             wr_i,
    input  logic [CNT_W-1:0] half_i,
    output logic             pending_o,
    output logic             out_clk_o,
    output logic             tick_o
);

    typedef struct packed {
        logic [CNT_W-1:0] half;     // active half-period H
        logic [CNT_W-1:0] pend;     // pending half-period P
        logic [CNT_W-1:0] cnt;      // counter C, always <= H-1
        logic             pending;
        logic             out;
        logic             tick;
    } chan_state_t;

    chan_state_t      state_q, state_d;
    logic [CNT_W-1:0] wr_half;
    logic             boundary;

    // A zero half-period would never toggle; clamp it to the minimum of 1.
    assign wr_half  = (half_i == '0) ? CNT_W'(1) : half_i;
    assign boundary = (state_q.cnt == state_q.half - CNT_W'(1));

    // Next-state: stop/clear when disabled, otherwise count and toggle at H-1.
    always_comb begin
        // NOTE: every field defaults to its current value first, so no path through the branches infers a latch.
        state_d      = state_q;
        state_d.tick = 1'b0;
        if (!enable_i) begin
            state_d.cnt = '0;
            state_d.out = 1'b0;
            if (state_q.pending) begin
                state_d.half    = state_q.pend;
                state_d.pending = 1'b0;
            end
            // Idle channel: a new divisor takes effect immediately.
            if (wr_i) begin
                state_d.half = wr_half;
            end
        end else if (boundary) begin
            state_d.cnt  = '0;
            state_d.out  = ~state_q.out;
            state_d.tick = ~state_q.out;
            if (state_q.pending) begin
                state_d.half    = state_q.pend;
                state_d.pending = 1'b0;
            end
            // A write landing on this boundary waits for the next one.
            if (wr_i) begin
                state_d.pend    = wr_half;
                state_d.pending = 1'b1;
            end
        end else begin
            state_d.cnt = state_q.cnt + CNT_W'(1);
            if (wr_i) begin
                state_d.pend    = wr_half;
                state_d.pending = 1'b1;
            end
        end
    end

    // State register with asynchronous reset to the default divisor.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the half-period register is reset, not left to power-up value, so a channel enabled at release runs at the default rate.
            state_q         <= '0;
            state_q.half    <= CNT_W'(DEFAULT_HALF);
        end else begin
            // NOTE: non-blocking assignment so every flop samples pre-edge values.
            state_q <= state_d;
        end
    end

    assign pending_o = state_q.pending;
    assign out_clk_o = state_q.out;
    assign tick_o    = state_q.tick;

endmodule

// File: rtl/prog_clock_divider.sv
// Multi-channel programmable clock divider: decodes the divisor write to
// one channel and reports ready from that channel's pending flag.
module prog_clock_divider
    import clkdiv_pkg::*;
#(
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned DEFAULT_HALF = DEFAULT_HALF_C
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [NUM_CH-1:0]    enable,
    prog_clock_divider_if.slave  cfg,
    output logic [NUM_CH-1:0]    out_clk,
    output logic [NUM_CH-1:0]    tick
);

    localparam int unsigned IDX_W = ch_idx_w(NUM_CH);

    logic [NUM_CH-1:0] ch_pending;
    logic [NUM_CH-1:0] ch_wr;

    // Channel decode; an index with no channel behind it is always ready and writes nothing.
    always_comb begin
        cfg.cfg_ready = 1'b1;
        ch_wr         = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg.cfg_ch == IDX_W'(i)) begin
                cfg.cfg_ready = ~ch_pending[i];
                ch_wr[i]      = cfg.cfg_valid & ~ch_pending[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clkdiv_channel #(
            .CNT_W        (CNT_W),
            .DEFAULT_HALF (DEFAULT_HALF)
        ) u_ch (
            .clk       (clock),
            .rst_n     (reset_n),
            .enable_i  (enable[g]),
            .wr_i      (ch_wr[g]),
            .half_i    (cfg.cfg_half),
            .pending_o (ch_pending[g]),
            .out_clk_o (out_clk[g]),
            .tick_o    (tick[g])
        );
    end

endmodule

// File: tb/tb_prog_clock_divider.sv
// Directed bench for prog_clock_divider: a per-cycle vector table from reset,
// then hand-written sequences for the multi-cycle corner cases.
module tb_prog_clock_divider;

    localparam int NUM_CH   = 3;
    localparam int CNT_W    = 8;
    localparam int DEF_HALF = 4;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [2:0]  enable;
    logic [2:0]  out_clk;
    logic [2:0]  tick;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;   // rising edges since the last reset release

    prog_clock_divider_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) cfg_bus ();

    prog_clock_divider #(
        .NUM_CH       (NUM_CH),
        .CNT_W        (CNT_W),
        .DEFAULT_HALF (DEF_HALF)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .enable  (enable),
        .cfg     (cfg_bus),
        .out_clk (out_clk),
        .tick    (tick)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       valid;
        logic [1:0] ch;
        logic [7:0] half;
        logic [2:0] exp_out;
        logic [2:0] exp_tick;
        logic       exp_rdy;
    } vec_t;

    vec_t vecs [13];

    // Expected channel-2 trace (edges 14..22) and channel-0 trace (edges 31..39).
    bit a_out [9] = '{1, 0, 1, 0, 0, 0, 0, 0, 1};
    bit a_rdy [9] = '{1, 1, 0, 1, 1, 1, 1, 1, 1};
    bit c_out [9] = '{0, 0, 0, 0, 1, 1, 0, 0, 1};
    bit c_tck [9] = '{0, 0, 0, 0, 1, 0, 0, 0, 1};
    bit c_rdy [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 1};

    // Closed-form models: channel 0 keeps H=4 (rises at 4, 12, 20 ...),
    // channel 1 switches to H=2 at edge 4 (rises every 4 edges from 4).
    function automatic logic m_out0(input int c);  return ((c / 4) % 2) == 1; endfunction
    function automatic logic m_tick0(input int c); return (c % 8) == 4;       endfunction
    function automatic logic m_out1(input int c);  return (c % 4) < 2;        endfunction
    function automatic logic m_tick1(input int c); return (c % 4) == 0;       endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
        cyc++;
    endtask

    task automatic drive(input logic v, input logic [1:0] ch, input logic [7:0] h);
        cfg_bus.cfg_valid = v;
        cfg_bus.cfg_ch    = ch;
        cfg_bus.cfg_half  = h;
    endtask

    initial begin
        // valid ch half   out     tick    rdy
        vecs[0]  = '{1'b1, 2'd2, 8'd0, 3'b000, 3'b000, 1'b1}; // idle ch2: H=1 directly
        vecs[1]  = '{1'b1, 2'd1, 8'd2, 3'b000, 3'b000, 1'b0}; // ch1 mid-period: pending
        vecs[2]  = '{1'b1, 2'd3, 8'd1, 3'b000, 3'b000, 1'b1}; // no channel 3: ready, dropped
        vecs[3]  = '{1'b0, 2'd1, 8'd0, 3'b011, 3'b011, 1'b1};
        vecs[4]  = '{1'b0, 2'd1, 8'd0, 3'b011, 3'b000, 1'b1};
        vecs[5]  = '{1'b0, 2'd1, 8'd0, 3'b001, 3'b000, 1'b1};
        vecs[6]  = '{1'b0, 2'd1, 8'd0, 3'b001, 3'b000, 1'b1};
        vecs[7]  = '{1'b0, 2'd1, 8'd0, 3'b010, 3'b010, 1'b1};
        vecs[8]  = '{1'b0, 2'd1, 8'd0, 3'b010, 3'b000, 1'b1};
        vecs[9]  = '{1'b0, 2'd1, 8'd0, 3'b000, 3'b000, 1'b1};
        vecs[10] = '{1'b0, 2'd1, 8'd0, 3'b000, 3'b000, 1'b1};
        vecs[11] = '{1'b0, 2'd1, 8'd0, 3'b011, 3'b011, 1'b1};
        vecs[12] = '{1'b0, 2'd1, 8'd0, 3'b011, 3'b000, 1'b1};

        reset_n = 1'b0;
        enable  = 3'b011;
        drive(1'b0, 2'd0, 8'd0);
        step();
        step();
        check("reset out_clk", 32'(out_clk), 32'd0);
        check("reset tick", 32'(tick), 32'd0);
        check("reset cfg_ready", 32'(cfg_bus.cfg_ready), 32'd1);

        reset_n = 1'b1;
        cyc     = 0;

        // Edges 1..13: channel 0 at H=4 from reset, channel 1 reprogrammed to 2.
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].valid, vecs[i].ch, vecs[i].half);
            step();
            check($sformatf("vec%0d out_clk", i), 32'(out_clk), 32'(vecs[i].exp_out));
            check($sformatf("vec%0d tick", i), 32'(tick), 32'(vecs[i].exp_tick));
            check($sformatf("vec%0d cfg_ready", i), 32'(cfg_bus.cfg_ready), 32'(vecs[i].exp_rdy));
        end

        // Edges 14..22: ch2 enabled at H=1 (period 2), rewritten to 5 on a boundary;
        // channels 0 and 1 must keep their phase.
        enable = 3'b111;
        for (int j = 0; j < 9; j++) begin
            drive(j == 2, 2'd2, 8'd5);
            step();
            check($sformatf("A%0d out2", j), 32'(out_clk[2]), 32'(a_out[j]));
            check($sformatf("A%0d tick2", j), 32'(tick[2]), 32'(a_out[j]));
            check($sformatf("A%0d cfg_ready", j), 32'(cfg_bus.cfg_ready), 32'(a_rdy[j]));
            check($sformatf("A%0d out0", j), 32'(out_clk[0]), 32'(m_out0(cyc)));
            check($sformatf("A%0d tick0", j), 32'(tick[0]), 32'(m_tick0(cyc)));
            check($sformatf("A%0d out1", j), 32'(out_clk[1]), 32'(m_out1(cyc)));
            check($sformatf("A%0d tick1", j), 32'(tick[1]), 32'(m_tick1(cyc)));
        end

        // Edge 23: drop ch0 enable while its output is high.
        enable = 3'b110;
        drive(1'b0, 2'd0, 8'd0);
        step();
        check("B drop out0", 32'(out_clk[0]), 32'd0);
        check("B drop tick0", 32'(tick[0]), 32'd0);

        // Edges 24..27: re-enable; first rise exactly H=4 edges later.
        enable = 3'b111;
        for (int j = 0; j < 4; j++) begin
            step();
            check($sformatf("B%0d out0", j), 32'(out_clk[0]), 32'(j == 3));
            check($sformatf("B%0d tick0", j), 32'(tick[0]), 32'(j == 3));
        end

        // Edges 28..30: high half continues.
        for (int j = 0; j < 3; j++) begin
            step();
            check($sformatf("C-pre%0d out0", j), 32'(out_clk[0]), 32'd1);
        end

        // Edges 31..39: write H=2 to ch0 on its boundary edge 31; one more old half follows.
        for (int j = 0; j < 9; j++) begin
            drive(j == 0, 2'd0, 8'd2);
            step();
            check($sformatf("C%0d out0", j), 32'(out_clk[0]), 32'(c_out[j]));
            check($sformatf("C%0d tick0", j), 32'(tick[0]), 32'(c_tck[j]));
            check($sformatf("C%0d cfg_ready", j), 32'(cfg_bus.cfg_ready), 32'(c_rdy[j]));
        end

        // Edge 40: ch1 boundary with a coincident write, leaving it pending.
        drive(1'b1, 2'd1, 8'd7);
        step();
        check("D out1 before reset", 32'(out_clk[1]), 32'(m_out1(cyc)));
        check("D pending ready", 32'(cfg_bus.cfg_ready), 32'd0);

        // Asynchronous reset between clock edges.
        drive(1'b0, 2'd1, 8'd0);
        #2;
        reset_n = 1'b0;
        #1;
        check("D async out_clk", 32'(out_clk), 32'd0);
        check("D async tick", 32'(tick), 32'd0);
        check("D async cfg_ready", 32'(cfg_bus.cfg_ready), 32'd1);

        enable = 3'b010;
        step();
        step();
        reset_n = 1'b1;
        cyc     = 0;

        // After release ch1 runs at the default H=4; the pending 7 is gone.
        for (int j = 0; j < 4; j++) begin
            step();
            check($sformatf("D%0d out_clk", j), 32'(out_clk), (j == 3) ? 32'd2 : 32'd0);
            check($sformatf("D%0d tick", j), 32'(tick), (j == 3) ? 32'd2 : 32'd0);
        end
        check("D final cfg_ready", 32'(cfg_bus.cfg_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
